// File: rtl/tmds_lane_serializer_if.sv
// Word input stream for the multi-lane serializer: valid/ready handshake plus all lane words.
interface tmds_lane_serializer_if #(
    parameter int unsigned CHANNELS   = 3,
    parameter int unsigned WORD_WIDTH = 10
);
    logic                           in_valid;
    logic                           in_ready;
    logic [CHANNELS*WORD_WIDTH-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/tmds_lane_serializer.sv
// Multi-lane word serializer: word FIFO feeding per-lane shift registers that emit
// BITS_PER_CLK bits per lane per clock, with idle-word insertion on starvation.
module tmds_lane_serializer #(
    parameter int unsigned           CHANNELS         = 3,
    parameter int unsigned           WORD_WIDTH       = 10,
    parameter int unsigned           BITS_PER_CLK     = 2,
    parameter int unsigned           FIFO_DEPTH       = 4,
    parameter logic [WORD_WIDTH-1:0] IDLE_WORD        = 10'b1101010100,
    parameter bit                    LSB_FIRST        = 1'b1,
    parameter logic [15:0]           UFLOW_COUNT_INIT = 16'h0000
) (
    input  logic                               bit_clock,
    input  logic                               reset_n,
    input  logic                               enable,
    tmds_lane_serializer_if.slave              in_bus,
    output logic [CHANNELS*BITS_PER_CLK-1:0]   ser_data,
    output logic                               word_strobe,
    output logic                               underflow,
    output logic [15:0]                        underflow_count,
    output logic [$clog2(FIFO_DEPTH):0]        fifo_level
);
    localparam int unsigned P  = WORD_WIDTH / BITS_PER_CLK;
    localparam int unsigned PW = (P > 1) ? $clog2(P) : 1;
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LW = AW + 1;
    localparam int unsigned DW = CHANNELS * WORD_WIDTH;
    localparam logic [PW-1:0] LAST_PHASE = PW'(P - 1);

    logic [DW-1:0]                        mem [FIFO_DEPTH];
    logic [AW-1:0]                        wr_ptr;
    logic [AW-1:0]                        rd_ptr;
    logic [LW-1:0]                        level_nxt;
    logic [DW-1:0]                        head;
    logic [PW-1:0]                        phase;
    logic [CHANNELS-1:0][WORD_WIDTH-1:0]  sr;
    logic                                 push;
    logic                                 load;
    logic                                 pop;

    // Handshake and word-boundary decode; a word pushed this cycle is never popped this cycle
    assign push = in_bus.in_valid & in_bus.in_ready;
    assign load = enable & (phase == LAST_PHASE);
    assign pop  = load & (fifo_level != '0);
    assign head = mem[rd_ptr];

    // FIFO storage (data only, no reset needed)
    always_ff @(posedge bit_clock) begin
        if (push) begin
            mem[wr_ptr] <= in_bus.in_data;
        end
    end

    // Occupancy after this cycle's push/pop
    always_comb begin
        level_nxt = fifo_level;
        if (push && !pop) begin
            level_nxt = fifo_level + LW'(1);
        end else if (!push && pop) begin
            level_nxt = fifo_level - LW'(1);
        end
    end

    // FIFO pointers, level and registered ready
    always_ff @(posedge bit_clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            fifo_level      <= '0;
            in_bus.in_ready <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            fifo_level      <= level_nxt;
            in_bus.in_ready <= (level_nxt != LW'(FIFO_DEPTH));
        end
    end

    // Bit phase within the current word; reset to the last phase so the first enabled edge loads
    always_ff @(posedge bit_clock or negedge reset_n) begin
        if (!reset_n) begin
            phase <= LAST_PHASE;
        end else if (enable) begin
            phase <= load ? '0 : phase + PW'(1);
        end
    end

    // Lane shift registers: load head word (or idle token) at word boundary, else shift toward output end
    always_ff @(posedge bit_clock or negedge reset_n) begin
        if (!reset_n) begin
            sr <= '0;
        end else if (load) begin
            sr <= pop ? head : {CHANNELS{IDLE_WORD}};
        end else if (enable) begin
            for (int c = 0; c < CHANNELS; c++) begin
                sr[c] <= LSB_FIRST ? (sr[c] >> BITS_PER_CLK) : (sr[c] << BITS_PER_CLK);
            end
        end
    end

    // Output end of each shift register, earliest bit in the lane LSB (pure flop outputs)
    always_comb begin
        ser_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            for (int j = 0; j < BITS_PER_CLK; j++) begin
                ser_data[k*BITS_PER_CLK + j] = LSB_FIRST ? sr[k][j] : sr[k][WORD_WIDTH-1-j];
            end
        end
    end

    // Load strobe, underflow pulse and saturating underflow counter
    always_ff @(posedge bit_clock or negedge reset_n) begin
        if (!reset_n) begin
            word_strobe     <= 1'b0;
            underflow       <= 1'b0;
            underflow_count <= UFLOW_COUNT_INIT;
        end else begin
            word_strobe <= load;
            underflow   <= load & ~pop;
            if (load && !pop && (underflow_count != 16'hFFFF)) begin
                underflow_count <= underflow_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_tmds_lane_serializer.sv
// Directed bench: word-level reference model checked every cycle, plus literal bit patterns.
module tb_tmds_lane_serializer;
    localparam int unsigned CH    = 3;
    localparam int unsigned W     = 10;
    localparam int unsigned BPC   = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned P     = W / BPC;
    localparam int unsigned DW    = CH * W;
    localparam int unsigned SW    = CH * BPC;
    localparam logic [W-1:0] IDLE = 10'b1101010100;

    logic bit_clock = 1'b0;
    logic reset_n   = 1'b0;
    logic enable    = 1'b0;
    logic enable_m  = 1'b0;
    bit   cmp_en    = 1'b0;

    tmds_lane_serializer_if #(.CHANNELS(CH), .WORD_WIDTH(W)) bus   ();
    tmds_lane_serializer_if #(.CHANNELS(CH), .WORD_WIDTH(W)) bus_m ();

    logic [SW-1:0] ser_data;
    logic          word_strobe;
    logic          underflow;
    logic [15:0]   underflow_count;
    logic [2:0]    fifo_level;

    logic [CH-1:0] ser_m;
    logic          strobe_m;
    logic          uf_m;
    logic [15:0]   count_m;
    logic [2:0]    level_m;

    tmds_lane_serializer #(
        .CHANNELS(CH), .WORD_WIDTH(W), .BITS_PER_CLK(BPC), .FIFO_DEPTH(DEPTH),
        .IDLE_WORD(IDLE), .LSB_FIRST(1'b1), .UFLOW_COUNT_INIT(16'h0000)
    ) dut (
        .bit_clock(bit_clock), .reset_n(reset_n), .enable(enable), .in_bus(bus),
        .ser_data(ser_data), .word_strobe(word_strobe), .underflow(underflow),
        .underflow_count(underflow_count), .fifo_level(fifo_level)
    );

    tmds_lane_serializer #(
        .CHANNELS(CH), .WORD_WIDTH(W), .BITS_PER_CLK(1), .FIFO_DEPTH(DEPTH),
        .IDLE_WORD(IDLE), .LSB_FIRST(1'b0), .UFLOW_COUNT_INIT(16'hFFFE)
    ) dut_m (
        .bit_clock(bit_clock), .reset_n(reset_n), .enable(enable_m), .in_bus(bus_m),
        .ser_data(ser_m), .word_strobe(strobe_m), .underflow(uf_m),
        .underflow_count(count_m), .fifo_level(level_m)
    );

    always #5 bit_clock = ~bit_clock;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: queue of whole words, current word and bit position inside it
    logic [DW-1:0] m_q [$];
    logic [DW-1:0] m_word;
    int            m_pos;
    logic          m_strobe;
    logic          m_uf;
    logic [15:0]   m_count;
    bit            m_push;

    always @(posedge bit_clock or negedge reset_n) begin
        if (!reset_n) begin
            m_q.delete();
            m_word   = '0;
            m_pos    = P - 1;
            m_strobe = 1'b0;
            m_uf     = 1'b0;
            m_count  = 16'h0000;
        end else begin
            m_push   = bus.in_valid && (m_q.size() < DEPTH);
            m_strobe = 1'b0;
            m_uf     = 1'b0;
            if (enable) begin
                if (m_pos == P - 1) begin
                    m_pos    = 0;
                    m_strobe = 1'b1;
                    if (m_q.size() > 0) begin
                        m_word = m_q.pop_front();
                    end else begin
                        m_word = {CH{IDLE}};
                        m_uf   = 1'b1;
                        if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
                    end
                end else begin
                    m_pos = m_pos + 1;
                end
            end
            if (m_push) m_q.push_back(bus.in_data);
        end
    end

    // Bits pos*BPC .. pos*BPC+BPC-1 of each lane word, earliest in lane LSB
    function automatic logic [SW-1:0] exp_ser(input logic [DW-1:0] w, input int pos);
        logic [SW-1:0] r;
        int b;
        r = '0;
        for (int k = 0; k < CH; k++) begin
            for (int j = 0; j < BPC; j++) begin
                b = pos * BPC + j;
                r[k*BPC + j] = w[k*W + b];
            end
        end
        return r;
    endfunction

    always @(negedge bit_clock) begin
        if (cmp_en) begin
            check("ser_data",    32'(ser_data),        32'(exp_ser(m_word, m_pos)));
            check("word_strobe", 32'(word_strobe),     32'(m_strobe));
            check("underflow",   32'(underflow),       32'(m_uf));
            check("uf_count",    32'(underflow_count), 32'(m_count));
            check("fifo_level",  32'(fifo_level),      32'(m_q.size()));
            check("in_ready",    32'(bus.in_ready),    32'(m_q.size() < DEPTH));
        end
    end

    task automatic wait_strobe(input string name);
        int n;
        n = 0;
        do begin
            @(negedge bit_clock);
            n++;
        end while (word_strobe !== 1'b1 && n < 40);
        check(name, 32'(word_strobe), 32'd1);
    endtask

    logic [1:0]    idle_pat [P] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b11};
    logic [DW-1:0] bp [5] = '{
        {10'h001, 10'h002, 10'h003},
        {10'h0F0, 10'h00F, 10'h3C3},
        {10'h155, 10'h2AA, 10'h3FF},
        {10'h123, 10'h321, 10'h0AB},
        {10'h3E1, 10'h01E, 10'h2D2}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus_m.in_valid = 1'b0;
        bus_m.in_data  = '0;

        // Reset values
        repeat (2) @(negedge bit_clock);
        check("rst_ser",    32'(ser_data),        32'd0);
        check("rst_ready",  32'(bus.in_ready),    32'd1);
        check("rst_level",  32'(fifo_level),      32'd0);
        check("rst_count",  32'(underflow_count), 32'd0);
        check("rst_strobe", 32'(word_strobe),     32'd0);
        cmp_en = 1'b1;

        // Starvation: idle token repeats, underflow each word
        reset_n = 1'b1;
        enable  = 1'b1;
        for (int wd = 0; wd < 2; wd++) begin
            for (int i = 0; i < P; i++) begin
                @(negedge bit_clock);
                check("starve_ser", 32'(ser_data), 32'({CH{idle_pat[i]}}));
                check("starve_strobe", 32'(word_strobe), (i == 0) ? 32'd1 : 32'd0);
                if (i == 0) begin
                    check("starve_uf",    32'(underflow),       32'd1);
                    check("starve_count", 32'(underflow_count), 32'(wd + 1));
                end
            end
        end

        // Push on a load edge into empty FIFO: idle is loaded, data waits one word
        bus.in_valid = 1'b1;
        bus.in_data  = {10'h3FF, 10'h2AA, 10'h155};
        @(negedge bit_clock);
        bus.in_valid = 1'b0;
        check("pushload_uf",    32'(underflow),  32'd1);
        check("pushload_level", 32'(fifo_level), 32'd1);
        repeat (P - 1) @(negedge bit_clock);
        for (int i = 0; i < P; i++) begin
            @(negedge bit_clock);
            check("data_ser", 32'(ser_data), 32'(6'b11_10_01));
            if (i == 0) check("data_uf", 32'(underflow), 32'd0);
        end

        // Backpressure with serializer frozen
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = bp[i];
            @(negedge bit_clock);
        end
        check("bp_level", 32'(fifo_level),   32'd4);
        check("bp_ready", 32'(bus.in_ready), 32'd0);
        @(negedge bit_clock);
        check("bp_held",  32'(fifo_level),   32'd4);
        enable = 1'b1;
        @(negedge bit_clock);
        check("bp_pop_strobe", 32'(word_strobe),  32'd1);
        check("bp_pop_level",  32'(fifo_level),   32'd3);
        check("bp_pop_ready",  32'(bus.in_ready), 32'd1);
        check("bp_w0_ser",     32'(ser_data),     32'(6'b01_10_11));
        @(negedge bit_clock);
        check("bp_5th_level",  32'(fifo_level),   32'd4);
        bus.in_valid = 1'b0;

        // Freeze mid-word at phase 2 of bp[1]
        wait_strobe("frz_sync");
        repeat (2) @(negedge bit_clock);
        check("frz_pre", 32'(ser_data), 32'(6'b11_00_00));
        enable = 1'b0;
        repeat (3) begin
            @(negedge bit_clock);
            check("frz_hold", 32'(ser_data), 32'(6'b11_00_00));
        end
        enable = 1'b1;
        @(negedge bit_clock);
        check("frz_resume", 32'(ser_data), 32'(6'b11_00_11));

        // Asynchronous reset mid-word
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_ser",    32'(ser_data),        32'd0);
        check("arst_level",  32'(fifo_level),      32'd0);
        check("arst_ready",  32'(bus.in_ready),    32'd1);
        check("arst_count",  32'(underflow_count), 32'd0);
        check("arst_strobe", 32'(word_strobe),     32'd0);
        @(negedge bit_clock);
        reset_n = 1'b1;
        @(negedge bit_clock);
        check("arst_flushed_uf", 32'(underflow), 32'd1);
        repeat (7) @(negedge bit_clock);

        // Mode instance: 1 bit/clk, MSB first, counter preloaded near saturation
        enable_m = 1'b1;
        @(negedge bit_clock);
        check("mode_first_uf",    32'(uf_m),    32'd1);
        check("mode_first_count", 32'(count_m), 32'hFFFF);
        bus_m.in_valid = 1'b1;
        bus_m.in_data  = {CH{10'h200}};
        @(negedge bit_clock);
        bus_m.in_valid = 1'b0;
        check("mode_level", 32'(level_m), 32'd1);
        n = 0;
        do begin
            @(negedge bit_clock);
            n++;
        end while (strobe_m !== 1'b1 && n < 40);
        check("mode_strobe", 32'(strobe_m), 32'd1);
        check("mode_data_uf", 32'(uf_m), 32'd0);
        for (int i = 0; i < 10; i++) begin
            check("mode_bit", 32'(ser_m), (i == 0) ? 32'(3'b111) : 32'(3'b000));
            @(negedge bit_clock);
        end
        check("sat_strobe", 32'(strobe_m), 32'd1);
        check("sat_uf",     32'(uf_m),     32'd1);
        check("sat_count",  32'(count_m),  32'hFFFF);

        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
